spi_mem_loader: RTL and testbench

SPI_MEM_LOADER -- requirements
Module: spi_mem_loader

---
 rtl/spi_mem_loader.sv | 163 ++++++++++++++++
 tb/tb_spi_mem_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
// spi_mem_loader
//   Serial loader that fills an instruction or data memory from a simple
//   select/mosi stream while the processor is held in load mode.
//
//   Parameters
//     ADDR_W     memory address width, depth 2^ADDR_W words
//     DATA_W     word width, also bits per serial word (must be >= 2)
//
//   Ports
//     clk        system clock, all state changes on rising edge
//     rst_n      asynchronous active-low reset
//     proc_en    1 = processor may run, 0 = load mode
//     csi        active-low select, instruction memory target
//     csd        active-low select, data memory target
//     mosi       serial data, MSB first, sampled every clk edge
//     imem_we    one-cycle write strobe, instruction memory
//     dmem_we    one-cycle write strobe, data memory
//     mem_addr   write address shared by both memories
//     mem_wdata  write data shared by both memories
//     proc_run   registered processor run enable
//     busy       high while in a load state
//     overflow   sticky, a word completed after the last address was written
//     sel_err    sticky, both selects were seen low together
module spi_mem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              proc_en,
    input  logic              csi,
    input  logic              csd,
    input  logic              mosi,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              proc_run,
    output logic              busy,
    output logic              overflow,
    output logic              sel_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_I = 2'd1;
    localparam logic [1:0] LOAD_D = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    // Only DATA_W-1 bits are held; the final bit comes straight from mosi.
    logic [DATA_W-2:0] shreg;
    logic [DATA_W-1:0] word_nxt;
    // Set once the top address has been written; further words overflow.
    logic              addr_full;
    logic              both_low;
    logic              entry;
    logic              shifting;
    logic              word_done;
    logic              load_nxt;

    assign both_low = !csi && !csd;
    assign word_nxt = {shreg, mosi};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // With proc_en high every select pattern is ignored,
                // including the both-low error pattern.
                if (!proc_en) begin
                    if (both_low)  state_nxt = ERR;
                    else if (!csi) state_nxt = LOAD_I;
                    else if (!csd) state_nxt = LOAD_D;
                end
            end
            LOAD_I: begin
                if (both_low) state_nxt = ERR;
                else if (csi) state_nxt = IDLE;  // covers a direct switch to csd
            end
            LOAD_D: begin
                if (both_low) state_nxt = ERR;
                else if (csd) state_nxt = IDLE;
            end
            default: begin
                if (csi && csd) state_nxt = IDLE;
            end
        endcase
    end

    assign load_nxt  = (state_nxt == LOAD_I) || (state_nxt == LOAD_D);
    assign entry     = (state == IDLE) && load_nxt;
    // Bits are taken only while staying in the same load state; any exit
    // (deselect, switch, error) drops the partial word.
    assign shifting  = (state != IDLE) && (state != ERR) && (state_nxt == state);
    assign word_done = shifting && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            addr_full <= 1'b0;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            proc_run  <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= load_nxt;
            proc_run <= proc_en && (state == IDLE);
            imem_we  <= 1'b0;
            dmem_we  <= 1'b0;

            // Address advances in the cycle after a strobe, and sticks at
            // the top once that address has been written.
            if ((imem_we || dmem_we) && !addr_full)
                mem_addr <= mem_addr + ADDR_W'(1);

            if (entry) begin
                // The entry edge already samples the MSB.
                bit_cnt   <= CNT_W'(1);
                shreg     <= (DATA_W-1)'(mosi);
                mem_addr  <= '0;
                addr_full <= 1'b0;
                overflow  <= 1'b0;
                sel_err   <= 1'b0;
            end else if (shifting) begin
                if (word_done) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    if (addr_full) begin
                        overflow <= 1'b1;
                    end else begin
                        imem_we   <= (state == LOAD_I);
                        dmem_we   <= (state == LOAD_D);
                        mem_wdata <= word_nxt;
                        if (mem_addr == LAST_ADDR)
                            addr_full <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    shreg   <= word_nxt[DATA_W-2:0];
                end
            end else begin
                bit_cnt <= '0;
                shreg   <= '0;
                if (state_nxt == ERR)
                    sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_loader.sv
// tb_spi_mem_loader
//   Scoreboard bench: each completed serial word that should be written is
//   queued as {target, addr, data}; a negedge monitor pops and compares on
//   every write strobe.
module tb_spi_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       proc_en = 1'b0;
    logic       csi = 1'b1;
    logic       csd = 1'b1;
    logic       mosi = 1'b0;
    logic       imem_we, dmem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       proc_run, busy, overflow, sel_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb[$];
    bit ovf_m;

    spi_mem_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .proc_en(proc_en), .csi(csi), .csd(csd),
        .mosi(mosi), .imem_we(imem_we), .dmem_we(dmem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .proc_run(proc_run),
        .busy(busy), .overflow(overflow), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (rst_n && (imem_we || dmem_we)) begin
            chk("we_excl", 32'(imem_we & dmem_we), 32'd0);
            if (sb.size() == 0)
                chk("unexp_we", 32'(imem_we | dmem_we), 32'd0);
            else
                chk("write", {19'd0, dmem_we, mem_addr, mem_wdata}, sb.pop_front());
        end
    end

    // Drive a frame of whole words; expectations are pushed as the last bit
    // of each word is driven.
    task automatic frame(input bit is_d, input logic [7:0] words[$], input bit close);
        int addr_m;
        logic [7:0] w;
        addr_m = 0;
        ovf_m  = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int b = 7; b >= 0; b--) begin
                @(negedge clk);
                csi  = is_d;
                csd  = !is_d;
                mosi = w[b];
                if (b == 0 && !proc_en) begin
                    if (addr_m < 16) begin
                        sb.push_back({19'd0, is_d, 4'(addr_m), w});
                        addr_m++;
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
            end
        end
        if (close) begin
            @(negedge clk);
            csi = 1'b1; csd = 1'b1; mosi = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] pat;

        // Reset state
        idle(3);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {30'd0, overflow, sel_err}, 0);
        rst_n = 1'b1;
        idle(2);

        // Two instruction words
        q = '{8'hA5, 8'h3C};
        frame(1'b0, q, 1'b1);
        idle(2);
        chk("i_busy_end", 32'(busy), 0);

        // 17 data words: 16 writes then overflow
        q = {};
        for (int i = 0; i <= 16; i++) q.push_back(8'(i));
        frame(1'b1, q, 1'b1);
        idle(2);
        chk("ovf_set", 32'(overflow), 32'(ovf_m));
        chk("ovf_addr", 32'(mem_addr), 32'd15);

        // Abort after 5 bits, then fresh frame
        for (int b = 0; b < 5; b++) begin
            @(negedge clk); csi = 1'b0; csd = 1'b1; mosi = 1'b1;
        end
        @(negedge clk); csi = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        q = '{8'h81};
        frame(1'b0, q, 1'b1);
        idle(2);
        chk("abort_ovf_clr", 32'(overflow), 0);

        // Both selects low mid-word
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); csi = 1'b0; csd = 1'b1; mosi = 1'b1;
        end
        @(negedge clk); csd = 1'b0;
        @(negedge clk);
        chk("err_flag", 32'(sel_err), 1);
        chk("err_busy", 32'(busy), 0);
        csd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("err_hold_busy", 32'(busy), 0);
        chk("err_hold_flag", 32'(sel_err), 1);
        csi = 1'b1;
        @(negedge clk);
        q = '{8'h5A};
        frame(1'b1, q, 1'b1);
        idle(2);
        chk("err_clr", 32'(sel_err), 0);

        // Direct switch from csi to csd
        q = '{8'hC3};
        frame(1'b0, q, 1'b0);
        @(negedge clk); csi = 1'b1; csd = 1'b0; mosi = 1'b0;
        q = '{8'hE7, 8'h42};
        frame(1'b1, q, 1'b1);
        idle(2);

        // Processor running: selects ignored
        proc_en = 1'b1;
        idle(2);
        q = '{8'hFF};
        frame(1'b0, q, 1'b0);
        @(negedge clk);
        chk("run_busy", 32'(busy), 0);
        chk("run_proc_run", 32'(proc_run), 1);
        csi = 1'b1;
        @(negedge clk);
        proc_en = 1'b0;
        @(negedge clk);
        chk("run_drop", 32'(proc_run), 0);
        idle(2);

        // Reset in the middle of a word
        q = '{8'h11};
        frame(1'b0, q, 1'b0);
        pat = 8'h22;
        for (int b = 7; b >= 4; b--) begin
            @(negedge clk); mosi = pat[b];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_we", {30'd0, imem_we, dmem_we}, 0);
        chk("mrst_addr", 32'(mem_addr), 0);
        chk("mrst_wdata", 32'(mem_wdata), 0);
        chk("mrst_busy", 32'(busy), 0);
        @(negedge clk);
        csi = 1'b1;
        rst_n = 1'b1;
        idle(12);
        q = '{8'h77};
        frame(1'b0, q, 1'b1);
        idle(4);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
